// File: rtl/brq_pkg.sv
// Shared types and constants for the branch resolve queue.
// BRQ_PC_MAX_W bounds the PC width any instance may use; narrower
// instances store their PC zero-extended in the entry.
package brq_pkg;

    localparam int BRQ_PC_MAX_W     = 64;
    localparam int BRQ_FALLTHRU_OFS = 8;

    typedef struct packed {
        logic [BRQ_PC_MAX_W-1:0] pc;
        logic                    pred_take;
    } brq_entry_t;

    typedef enum logic {
        BRQ_NORMAL,
        BRQ_RECOVER
    } brq_state_t;

endpackage

// File: rtl/brq_stat_counter.sv
// Saturating 32-bit event counter: holds at all-ones instead of wrapping.
module brq_stat_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc,
    output logic [31:0] o_value
);

    logic [31:0] r_value;

    // Count enabled events, sticking at the maximum value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
        end else if (i_inc && (r_value != '1)) begin
            r_value <= r_value + 32'd1;
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions. It checks each one against
// the execute-stage outcome, pulses a one-cycle redirect on a mispredict and
// drives the registered predictor-update stream.
// Optional statistics counters are built when BRQ_STATS_EN is defined.
// PC_W must not exceed brq_pkg::BRQ_PC_MAX_W.
module branch_resolve_queue
    import brq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq_valid,
    input  logic [PC_W-1:0]          enq_pc,
    input  logic                     enq_pred_take,
    input  logic                     res_valid,
    input  logic                     res_take,
    input  logic [PC_W-1:0]          res_target,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     pred_wrong,
    output logic [PC_W-1:0]          redirect_pc,
    output logic                     upd_valid,
    output logic [PC_W-1:0]          upd_pc,
    output logic                     upd_take
`ifdef BRQ_STATS_EN
    ,
    output logic [31:0]              stat_branches,
    output logic [31:0]              stat_mispred
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    brq_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    brq_state_t       r_state;
    brq_state_t       w_state_nxt;

    logic [PC_W-1:0]  r_redirect_pc;
    logic             r_upd_valid;
    logic [PC_W-1:0]  r_upd_pc;
    logic             r_upd_take;

    brq_entry_t       w_head;
    logic [PC_W-1:0]  w_head_pc;
    logic [PC_W-1:0]  w_fallthru_pc;
    logic             w_pop;
    logic             w_mispred;
    logic             w_push;

    assign w_head        = r_mem[r_rd_ptr];
    assign w_head_pc     = PC_W'(w_head.pc);
    assign w_fallthru_pc = w_head_pc + PC_W'(BRQ_FALLTHRU_OFS);

    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_W'(DEPTH));
    assign count = r_count;

    // A pop at full frees its slot on the same edge, so a push may join it.
    // Anything arriving alongside a mispredict or during recovery is wrong-path.
    assign w_pop     = res_valid & ~empty;
    assign w_mispred = w_pop & (w_head.pred_take != res_take);
    assign w_push    = enq_valid & (~full | w_pop) & (r_state == BRQ_NORMAL) & ~w_mispred;

    // Recovery state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BRQ_NORMAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Enter recovery on a mispredict and leave it after exactly one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BRQ_NORMAL:  if (w_mispred) w_state_nxt = BRQ_RECOVER;
            BRQ_RECOVER: w_state_nxt = BRQ_NORMAL;
            default:     w_state_nxt = BRQ_NORMAL;
        endcase
    end

    assign pred_wrong = (r_state == BRQ_RECOVER);

    // Pointer and occupancy bookkeeping; a mispredict flushes all younger entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_mispred) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
        end
    end

    // Entry storage needs no reset; the pointers decide what is live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{pc: BRQ_PC_MAX_W'(enq_pc), pred_take: enq_pred_take};
        end
    end

    // Registered redirect target and predictor-update stream, one cycle after resolve.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redirect_pc <= '0;
            r_upd_valid   <= 1'b0;
            r_upd_pc      <= '0;
            r_upd_take    <= 1'b0;
        end else begin
            r_upd_valid <= w_pop;
            if (w_pop) begin
                r_upd_pc   <= w_head_pc;
                r_upd_take <= res_take;
            end
            if (w_mispred) begin
                r_redirect_pc <= res_take ? res_target : w_fallthru_pc;
            end
        end
    end

    assign redirect_pc = r_redirect_pc;
    assign upd_valid   = r_upd_valid;
    assign upd_pc      = r_upd_pc;
    assign upd_take    = r_upd_take;

`ifdef BRQ_STATS_EN
    brq_stat_counter u_stat_branches (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_pop),
        .o_value (stat_branches)
    );

    brq_stat_counter u_stat_mispred (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_mispred),
        .o_value (stat_mispred)
    );
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue (DEPTH=4, PC_W=32).
// Statistics checks are included when BRQ_STATS_EN is defined.
module tb_branch_resolve_queue;

    logic        clk;
    logic        rst;
    logic        enq_valid;
    logic [31:0] enq_pc;
    logic        enq_pred_take;
    logic        res_valid;
    logic        res_take;
    logic [31:0] res_target;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic        pred_wrong;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_take;
`ifdef BRQ_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
`endif

    int vectors;
    int miscompares;

    branch_resolve_queue #(.DEPTH(4), .PC_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .enq_valid     (enq_valid),
        .enq_pc        (enq_pc),
        .enq_pred_take (enq_pred_take),
        .res_valid     (res_valid),
        .res_take      (res_take),
        .res_target    (res_target),
        .full          (full),
        .empty         (empty),
        .count         (count),
        .pred_wrong    (pred_wrong),
        .redirect_pc   (redirect_pc),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_take      (upd_take)
`ifdef BRQ_STATS_EN
        ,
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, clock it in, and settle 1 time unit past the edge.
    task automatic applyStimulus(input logic ev, input logic [31:0] pc, input logic pt,
                                 input logic rv, input logic rt, input logic [31:0] tgt);
        enq_valid     = ev;
        enq_pc        = pc;
        enq_pred_take = pt;
        res_valid     = rv;
        res_take      = rt;
        res_target    = tgt;
        @(posedge clk);
        #1;
    endtask

    // One comparison: observed against the hand-computed expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        enq_valid = 0; enq_pc = 0; enq_pred_take = 0;
        res_valid = 0; res_take = 0; res_target = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_empty",       32'(empty),       32'd1);
        checkOutput("rst_full",        32'(full),        32'd0);
        checkOutput("rst_count",       32'(count),       32'd0);
        checkOutput("rst_pred_wrong",  32'(pred_wrong),  32'd0);
        checkOutput("rst_redirect",    redirect_pc,      32'd0);
        checkOutput("rst_upd_valid",   32'(upd_valid),   32'd0);
        checkOutput("rst_upd_pc",      upd_pc,           32'd0);
        checkOutput("rst_upd_take",    32'(upd_take),    32'd0);
`ifdef BRQ_STATS_EN
        checkOutput("rst_stat_br",     stat_branches,    32'd0);
        checkOutput("rst_stat_mp",     stat_mispred,     32'd0);
`endif
        rst = 1'b0;

        // Correct prediction: push 0x100 (taken), resolve taken.
        applyStimulus(1, 32'h100, 1, 0, 0, 32'h0);
        checkOutput("p1_count",        32'(count),       32'd1);
        checkOutput("p1_empty",        32'(empty),       32'd0);
        applyStimulus(0, 32'h0, 0, 1, 1, 32'h200);
        checkOutput("r1_upd_valid",    32'(upd_valid),   32'd1);
        checkOutput("r1_upd_pc",       upd_pc,           32'h100);
        checkOutput("r1_upd_take",     32'(upd_take),    32'd1);
        checkOutput("r1_pred_wrong",   32'(pred_wrong),  32'd0);
        checkOutput("r1_empty",        32'(empty),       32'd1);
        applyStimulus(0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("idle_upd_valid",  32'(upd_valid),   32'd0);

        // Mispredict with younger entries and a same-cycle enqueue.
        applyStimulus(1, 32'h100, 0, 0, 0, 32'h0);
        applyStimulus(1, 32'h120, 1, 0, 0, 32'h0);
        applyStimulus(1, 32'h140, 1, 0, 0, 32'h0);
        checkOutput("p3_count",        32'(count),       32'd3);
        applyStimulus(1, 32'h160, 1, 1, 1, 32'h400);
        checkOutput("mp1_pred_wrong",  32'(pred_wrong),  32'd1);
        checkOutput("mp1_redirect",    redirect_pc,      32'h400);
        checkOutput("mp1_count",       32'(count),       32'd0);
        checkOutput("mp1_empty",       32'(empty),       32'd1);
        checkOutput("mp1_upd_valid",   32'(upd_valid),   32'd1);
        checkOutput("mp1_upd_pc",      upd_pc,           32'h100);
        // Push during recovery is wrong-path.
        applyStimulus(1, 32'h180, 1, 0, 0, 32'h0);
        checkOutput("rec_pulse_end",   32'(pred_wrong),  32'd0);
        checkOutput("rec_drop_count",  32'(count),       32'd0);

        // Predicted taken, actually not-taken: fall-through redirect.
        applyStimulus(1, 32'h300, 1, 0, 0, 32'h0);
        checkOutput("p300_count",      32'(count),       32'd1);
        applyStimulus(0, 32'h0, 0, 1, 0, 32'h999);
        checkOutput("mp2_pred_wrong",  32'(pred_wrong),  32'd1);
        checkOutput("mp2_redirect",    redirect_pc,      32'h308);
        checkOutput("mp2_upd_take",    32'(upd_take),    32'd0);
        checkOutput("mp2_upd_pc",      upd_pc,           32'h300);
        applyStimulus(0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("mp2_pulse_end",   32'(pred_wrong),  32'd0);

        // Fill to DEPTH, with pointer wrap, then overflow push is dropped.
        applyStimulus(1, 32'h500, 1, 0, 0, 32'h0);
        applyStimulus(1, 32'h504, 0, 0, 0, 32'h0);
        applyStimulus(1, 32'h508, 1, 0, 0, 32'h0);
        applyStimulus(1, 32'h50C, 0, 0, 0, 32'h0);
        checkOutput("fill_full",       32'(full),        32'd1);
        checkOutput("fill_count",      32'(count),       32'd4);
        applyStimulus(1, 32'h510, 1, 0, 0, 32'h0);
        checkOutput("ovf_count",       32'(count),       32'd4);
        checkOutput("ovf_full",        32'(full),        32'd1);

        // Push and correct resolve together at full.
        applyStimulus(1, 32'h600, 1, 1, 1, 32'h700);
        checkOutput("pp_count",        32'(count),       32'd4);
        checkOutput("pp_upd_pc",       upd_pc,           32'h500);
        checkOutput("pp_pred_wrong",   32'(pred_wrong),  32'd0);

        // Drain back-to-back in FIFO order.
        applyStimulus(0, 32'h0, 0, 1, 0, 32'h0);
        checkOutput("d1_upd_valid",    32'(upd_valid),   32'd1);
        checkOutput("d1_upd_pc",       upd_pc,           32'h504);
        checkOutput("d1_count",        32'(count),       32'd3);
`ifdef BRQ_STATS_EN
        checkOutput("stat_br5",        stat_branches,    32'd5);
        checkOutput("stat_mp2",        stat_mispred,     32'd2);
`endif
        applyStimulus(0, 32'h0, 0, 1, 1, 32'h0);
        checkOutput("d2_upd_valid",    32'(upd_valid),   32'd1);
        checkOutput("d2_upd_pc",       upd_pc,           32'h508);
        applyStimulus(0, 32'h0, 0, 1, 0, 32'h0);
        checkOutput("d3_upd_pc",       upd_pc,           32'h50C);
        checkOutput("d3_pred_wrong",   32'(pred_wrong),  32'd0);
        applyStimulus(0, 32'h0, 0, 1, 1, 32'h0);
        checkOutput("d4_upd_pc",       upd_pc,           32'h600);
        checkOutput("d4_upd_take",     32'(upd_take),    32'd1);
        checkOutput("d4_empty",        32'(empty),       32'd1);
        checkOutput("d4_pred_wrong",   32'(pred_wrong),  32'd0);

        // Resolve while empty is ignored.
        applyStimulus(0, 32'h0, 0, 1, 0, 32'h0);
        checkOutput("er_upd_valid",    32'(upd_valid),   32'd0);
        checkOutput("er_pred_wrong",   32'(pred_wrong),  32'd0);
        checkOutput("er_count",        32'(count),       32'd0);
        applyStimulus(0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("er_no_pulse",     32'(pred_wrong),  32'd0);

        // Asynchronous reset with three entries live and an update in flight.
        applyStimulus(1, 32'h800, 1, 0, 0, 32'h0);
        applyStimulus(1, 32'h804, 1, 0, 0, 32'h0);
        applyStimulus(1, 32'h808, 1, 0, 0, 32'h0);
        applyStimulus(1, 32'h80C, 1, 1, 1, 32'h0);
        checkOutput("pre_rst_count",   32'(count),       32'd3);
        checkOutput("pre_rst_upd",     32'(upd_valid),   32'd1);
        enq_valid = 0; res_valid = 0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("ar_count",        32'(count),       32'd0);
        checkOutput("ar_empty",        32'(empty),       32'd1);
        checkOutput("ar_upd_valid",    32'(upd_valid),   32'd0);
        checkOutput("ar_upd_pc",       upd_pc,           32'd0);
        checkOutput("ar_redirect",     redirect_pc,      32'd0);
        checkOutput("ar_pred_wrong",   32'(pred_wrong),  32'd0);
`ifdef BRQ_STATS_EN
        checkOutput("ar_stat_br",      stat_branches,    32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(0, 32'h0, 0, 1, 1, 32'h0);
        checkOutput("post_rst_no_upd", 32'(upd_valid),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

In-order queue of in-flight conditional-branch predictions, sitting between the local-history predictor (decode side) and the execute-stage branch unit. It records each predicted branch at decode, checks the prediction against the execute-stage outcome, and raises a one-cycle mispredict/redirect. It also emits the registered predictor-update stream (`upd_valid`/`upd_pc`/`upd_take`) consumed by the predictor's PHT/BHT update port one cycle later (M stage).

## Interface
- `DEPTH`, default 4: queue entries; power of two, ≥2.
- `PC_W`, default 32: PC width.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `enq_valid`  in  1: push a branch; driven as `branchD & ~stallD & ~flushD`.
- `enq_pc`  in  `PC_W`: PC of the decode-stage branch.
- `enq_pred_take`  in  1: predictor's `pred_takeD`.
- `res_valid`  in  1: execute-stage branch resolved this cycle.
- `res_take`  in  1: actual direction (`actual_takeE`).
- `res_target`  in  `PC_W`: computed branch target.
- `full`, `empty`  out  1: queue status.
- `count`  out  `$clog2(DEPTH)+1`: occupied entries.
- `pred_wrong`  out  1: registered mispredict pulse.
- `redirect_pc`  out  `PC_W`: correct fetch PC; valid while `pred_wrong`=1.
- `upd_valid`  out  1: predictor update strobe (`branchM`).
- `upd_pc`  out  `PC_W`: PC of the resolved branch (`pcM`).
- `upd_take`  out  1: actual direction (`actual_takeM`).

## Operation
- Storage: circular buffer of `{pc, pred_take}`, with read/write pointers `$clog2(DEPTH)` bits wide that wrap modulo `DEPTH`. `count` is tracked explicitly; `full` is `count==DEPTH`, `empty` is `count==0`.
- FSM has two states:
  - NORMAL → RECOVER when a resolution mispredicts.
  - RECOVER → NORMAL unconditionally after one cycle.
  - `pred_wrong` = (state==RECOVER).
- Enqueue: accepted iff `enq_valid & ~full & state==NORMAL`.
  - Enqueue while `full` is a pipeline bug: the entry is dropped and the queue is unchanged.
  - Enqueue during RECOVER is wrong-path and is dropped.
- Resolve: when `res_valid & ~empty`, pop the head.
  - Mispredict = `head.pred_take != res_take`.
  - `redirect_pc` is registered as `res_take ? res_target : head.pc + 8` (the fall-through skips the delay slot), in `PC_W`-bit arithmetic with wrap.
  - On mispredict, every younger entry is discarded (count→0, `rd_ptr=wr_ptr`). A same-cycle enqueue is also discarded.
- `res_valid` while `empty` is ignored: no pop, no update, no mispredict.
- Simultaneous accepted enqueue and correct resolve: push and pop both happen and `count` is unchanged. This holds at `full` too, because the pop frees the slot in the same edge.
- Update stream: on every valid resolve (correct or not), the next cycle drives `upd_valid`=1, `upd_pc`=`head.pc`, `upd_take`=`res_take`.

## Timing
- Reset values: `pred_wrong`=0, `redirect_pc`=0, `upd_valid`=0, `upd_pc`=0, `upd_take`=0, `empty`=1, `full`=0, `count`=0; pointers 0; state NORMAL.
- Reset asserted mid-operation clears the queue immediately (asynchronously); no update or redirect is emitted for lost entries.
- Enqueue-to-resolvable latency is 1 cycle: an entry pushed at edge N may be resolved in cycle N+1.
- Resolve-to-`pred_wrong`/`redirect_pc` latency is 1 cycle. The pulse lasts exactly 1 cycle.
- Resolve-to-`upd_*` latency is 1 cycle, aligned with `pred_wrong`.
- Back-to-back resolves produce back-to-back update strobes.

## Configuration
- `BRQ_STATS_EN` defined:
  - Adds output ports `stat_branches` (32 bits, count of valid resolves) and `stat_mispred` (32 bits, count of mispredicts).
  - Both saturate at 2^32−1 and are cleared by `rst`.
- `BRQ_STATS_EN` undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package `brq_pkg`:
  - `brq_entry_t` struct `{pc, pred_take}`.
  - `brq_state_t` enum `{BRQ_NORMAL, BRQ_RECOVER}`.
  - Constant `BRQ_FALLTHRU_OFS = 8`.
- One sub-module, `brq_stat_counter`: a saturating 32-bit counter with increment enable. It is instantiated twice, only under `BRQ_STATS_EN`.

## Test plan
- Push PC 0x100 (pred 1), then resolve taken with target 0x200 → next cycle `upd_valid`=1, `upd_pc`=0x100, `upd_take`=1, `pred_wrong`=0, `empty`=1.
- Push 0x100 (pred 0), 0x120, 0x140; resolve 0x100 taken to 0x400 → `pred_wrong` pulses 1 cycle, `redirect_pc`=0x400, `count`=0; a same-cycle enqueue is dropped.
- Push 0x300 (pred 1); resolve not-taken → `redirect_pc`=0x308, `upd_take`=0.
- Fill to DEPTH=4 and push again → `full`=1 and `count` stays 4; then push and correct-resolve in the same cycle → `count` stays 4 and FIFO order is preserved across pointer wrap.
- `res_valid` with `empty` → no `upd_valid` and no `pred_wrong`. Assert `rst` mid-queue (3 entries) → all outputs return to reset values the same cycle.
- With `BRQ_STATS_EN`: 5 resolves, 2 of them wrong → `stat_branches`=5, `stat_mispred`=2.
